// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants and hex-to-segment mapping for the display scan path
// Contents:
//   SEG_BLANK, ANODE_OFF : all-off values for the active-low outputs
//   NUM_DIGITS           : number of scanned digits
//   disp_state_t         : scan FSM encodings (BLANK, DRIVE)
//   HEX7_TABLE, hex7()   : 16-entry active-low {a,b,c,d,e,f,g} table shared with any segment driver
package disp_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [7:0] ANODE_OFF  = 8'hFF;
  localparam int         NUM_DIGITS = 8;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } disp_state_t;

  // Element 0 is the leftmost entry, so the list reads in hex order 0..F.
  localparam logic [0:15][6:0] HEX7_TABLE = {
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  function automatic logic [6:0] hex7(input logic [3:0] n);
    return HEX7_TABLE[n];
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_hex_to_7seg.sv
// rtl/disp_scan_ctrl_hex_to_7seg.sv - combinational nibble to active-low 7-segment decoder
// Ports:
//   nib [3:0] in  : hex digit
//   seg [6:0] out : segments {a,b,c,d,e,f,g}, active low
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex7(nib);

endmodule

// File: rtl/disp_scan_ctrl.sv
// rtl/disp_scan_ctrl.sv - 8-digit 7-segment scan controller with ghosting blank window
// Optional feature macro: DISP_DP_EN (adds dp_in/dp decimal point path)
// Ports:
//   clk            in  : system clock, rising edge
//   reset          in  : synchronous active-high reset
//   en             in  : scan enable; low freezes the scan and blanks the display
//   nib [3:0]      in  : nibble from the external mux for the current sel
//   dp_in [7:0]    in  : per-digit decimal point, 1 = lit (DISP_DP_EN only)
//   sel [2:0]      out : digit select to the mux
//   anode [7:0]    out : digit enables, active low
//   seg [6:0]      out : segments {a,b,c,d,e,f,g}, active low
//   dp             out : decimal point, active low (DISP_DP_EN only)
//   digit_tick     out : one-cycle pulse in the cycle sel advances
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] nib,
`ifdef DISP_DP_EN
  input  logic [7:0] dp_in,
  output logic       dp,
`endif
  output logic [2:0] sel,
  output logic [7:0] anode,
  output logic [6:0] seg,
  output logic       digit_tick
);

  localparam int DIV_W   = $clog2(REFRESH_DIV);
  localparam int BLK_W   = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);
  localparam int BC_LAST = (BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BC_LAST);

  disp_state_t      state, state_nxt;
  logic [DIV_W-1:0] div_cnt, div_nxt;
  logic [BLK_W-1:0] blank_cnt, blank_nxt, blank_eff;
  logic [2:0]       sel_nxt;
  logic [7:0]       anode_nxt;
  logic [6:0]       seg_nxt, seg_hex;
  logic             tick_nxt, tc, en_q;
`ifdef DISP_DP_EN
  logic             dp_nxt;
`endif

  hex_to_7seg u_hex (
    .nib (nib),
    .seg (seg_hex)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= BLANK;
      div_cnt    <= '0;
      blank_cnt  <= '0;
      sel        <= 3'd0;
      anode      <= ANODE_OFF;
      seg        <= SEG_BLANK;
      digit_tick <= 1'b0;
      en_q       <= 1'b0;
`ifdef DISP_DP_EN
      dp         <= 1'b1;
`endif
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_nxt;
      blank_cnt  <= blank_nxt;
      sel        <= sel_nxt;
      anode      <= anode_nxt;
      seg        <= seg_nxt;
      digit_tick <= tick_nxt;
      en_q       <= en;
`ifdef DISP_DP_EN
      dp         <= dp_nxt;
`endif
    end
  end

  // Output registers follow the next state, so anodes are dark for exactly
  // the cycles the FSM sits in BLANK.
  always_comb begin
    state_nxt = state;
    div_nxt   = div_cnt;
    blank_nxt = blank_cnt;
    sel_nxt   = sel;
    tick_nxt  = 1'b0;
    anode_nxt = ANODE_OFF;
    seg_nxt   = SEG_BLANK;
`ifdef DISP_DP_EN
    dp_nxt    = 1'b1;
`endif
    tc        = (div_cnt == DIV_LAST);
    // blank_cnt holds while disabled; a fresh enable restarts the window from zero.
    blank_eff = en_q ? blank_cnt : '0;

    if (en) begin
      if (state == BLANK) begin
        blank_nxt = blank_eff + 1'b1;
        if (blank_eff == BLK_LAST) begin
          state_nxt = DRIVE;
        end
      end

      if (state_nxt == DRIVE) begin
        anode_nxt = ~(8'b1 << sel);
        seg_nxt   = seg_hex;
`ifdef DISP_DP_EN
        dp_nxt    = ~dp_in[sel];
`endif
      end

      if (tc) begin
        // nib still belongs to the old digit here, so this edge is always dark.
        div_nxt   = '0;
        sel_nxt   = sel + 3'd1;
        tick_nxt  = 1'b1;
        blank_nxt = '0;
        state_nxt = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        anode_nxt = ANODE_OFF;
        seg_nxt   = SEG_BLANK;
`ifdef DISP_DP_EN
        dp_nxt    = 1'b1;
`endif
      end else begin
        div_nxt = div_cnt + 1'b1;
      end
    end else begin
      state_nxt = BLANK;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb/tb_disp_scan_ctrl.sv - directed self-checking bench for disp_scan_ctrl
module tb_disp_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset, en;
  logic [3:0] nib;
  logic [2:0] sel;
  logic [7:0] anode;
  logic [6:0] seg;
  logic       digit_tick;
`ifdef DISP_DP_EN
  logic [7:0] dp_in;
  logic       dp;
`endif

  logic       force_mode;
  logic [3:0] force_nib;
  logic [6:0] hex_ref [16];
  int         total = 0;
  int         bad = 0;
  int         k;

  always #5 clk = ~clk;

  // Mux model: nibble is sel+1 unless a forced value is being applied.
  assign nib = force_mode ? force_nib : (4'(sel) + 4'd1);

  disp_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .nib        (nib),
`ifdef DISP_DP_EN
    .dp_in      (dp_in),
    .dp         (dp),
`endif
    .sel        (sel),
    .anode      (anode),
    .seg        (seg),
    .digit_tick (digit_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (k=%0d)", tag, got, exp, k);
    end
  endtask

  // Expected outputs k edges after reset release in an uninterrupted scan.
  task automatic chk_scan(input string tag);
    int         p;
    logic [2:0] es;
    logic [7:0] ea;
    logic [6:0] eseg;
    logic [3:0] en_nib;
    p  = k % 8;
    es = 3'((k / 8) % 8);
    en_nib = force_mode ? force_nib : (4'(es) + 4'd1);
    if (p < 2) begin
      ea   = 8'hFF;
      eseg = 7'h7F;
    end else begin
      ea   = ~(8'h01 << es);
      eseg = hex_ref[en_nib];
    end
    chk({tag, ".sel"},   {5'd0, sel}, {5'd0, es});
    chk({tag, ".anode"}, anode, ea);
    chk({tag, ".seg"},   {1'b0, seg}, {1'b0, eseg});
    chk({tag, ".tick"},  {7'd0, digit_tick}, {7'd0, (k > 0 && p == 0)});
`ifdef DISP_DP_EN
    chk({tag, ".dp"},    {7'd0, dp}, {7'd0, (ea != 8'hFB)});
`endif
  endtask

  initial begin
    int v;
    int guard;
    hex_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    force_mode = 1'b0;
    force_nib  = 4'd0;
    reset      = 1'b1;
    en         = 1'b0;
    k          = 0;
`ifdef DISP_DP_EN
    dp_in      = 8'h04;
`endif

    // 1. reset held 3 clocks
    repeat (3) step();
    chk("rst.anode", anode, 8'hFF);
    chk("rst.seg",   {1'b0, seg}, 8'h7F);
    chk("rst.sel",   {5'd0, sel}, 8'd0);
    chk("rst.tick",  {7'd0, digit_tick}, 8'd0);
`ifdef DISP_DP_EN
    chk("rst.dp",    {7'd0, dp}, 8'd1);
`endif
    reset = 1'b0;
    en    = 1'b1;

    // 2. free run across a full sel wrap
    for (int i = 0; i < 66; i++) begin
      step();
      k++;
      chk_scan("run");
    end

    // 3. forced nibbles 0..F observed while driving
    force_mode = 1'b1;
    v = 0;
    guard = 0;
    while (v < 16 && guard < 200) begin
      force_nib = 4'(v);
      step();
      k++;
      guard++;
      chk_scan("hex");
      if (k % 8 >= 2) v++;
    end
    chk("hex.guard", {7'd0, (v == 16)}, 8'd1);
    force_mode = 1'b0;

    // 4. disable mid-DRIVE at sel=3, div_cnt=4
    guard = 0;
    while (!((k % 8 == 4) && ((k / 8) % 8 == 3)) && guard < 100) begin
      step();
      k++;
      guard++;
      chk_scan("pre_en");
    end
    chk("en.guard", {7'd0, (guard < 100)}, 8'd1);
    en = 1'b0;
    step();
    chk("en0.anode", anode, 8'hFF);
    chk("en0.seg",   {1'b0, seg}, 8'h7F);
    chk("en0.tick",  {7'd0, digit_tick}, 8'd0);
    for (int i = 0; i < 19; i++) begin
      step();
      chk("en0.sel",   {5'd0, sel}, 8'd3);
      chk("en0.hold",  anode, 8'hFF);
    end
    en = 1'b1;
    step();
    chk("en1.blank", anode, 8'hFF);
    step();
    chk("en1.anode", anode, 8'hF7);
    chk("en1.seg",   {1'b0, seg}, {1'b0, hex_ref[4]});
    step();
    chk("en1.anode2", anode, 8'hF7);
    step();
    chk("en1.sel",   {5'd0, sel}, 8'd4);
    chk("en1.tick",  {7'd0, digit_tick}, 8'd1);
    chk("en1.off",   anode, 8'hFF);
    k = 32;

    // 5. reset pulse at sel=5, div_cnt=4
    while (k < 44) begin
      step();
      k++;
      chk_scan("pre_rst");
    end
    reset = 1'b1;
    step();
    chk("rst2.sel",   {5'd0, sel}, 8'd0);
    chk("rst2.anode", anode, 8'hFF);
    chk("rst2.tick",  {7'd0, digit_tick}, 8'd0);
    chk("rst2.seg",   {1'b0, seg}, 8'h7F);
    reset = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      k++;
      chk_scan("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
